axil_native_bridge: RTL

//  AXI4-Lite slave to native register-bus bridge, second generation. Adds independent AW/W arrival order,
//  a native write acknowledge, per-access timeout (SLVERR), address-window decode (DECERR), byte strobes and

---
 rtl/axil_native_bridge_pkg.sv | 18 +
 rtl/axil_native_bridge_timeout.sv | 37 +++
 rtl/axil_native_bridge.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_native_bridge_pkg.sv
// Shared types and response codes for the AXI4-Lite to native bridge.
// Imported by the bridge top and its timeout counter.
package axil_native_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_COLLECT,
    S_WR_WAIT,
    S_WR_RESP,
    S_RD_WAIT,
    S_RD_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_native_bridge_timeout.sv
// Loadable down-counter bounding the wait for a native acknowledge.
// Expires on the TIMEOUT-th cycle after the strobe cycle is loaded.
module axil_native_timeout
  import axil_native_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_stop,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;
  logic         r_run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= W'(TIMEOUT - 1);
      r_run <= 1'b1;
    end else if (i_stop) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (r_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = r_run && (r_cnt == '0);

endmodule

// File: rtl/axil_native_bridge.sv
// AXI4-Lite slave to native register bus bridge with decode, timeout,
// byte strobes and read/write arbitration; one access in flight.
module axil_native_bridge
  import axil_native_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH:0]   ADDR_SPAN  = (ADDR_WIDTH+1)'(4096),
  parameter int                    TIMEOUT    = 16,
  parameter int                    ARB_MODE   = 0
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [2:0]              AXI_AWPROT,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [2:0]              AXI_ARPROT,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  output logic                    WEN,
  output logic [ADDR_WIDTH-1:0]   WADDR,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WACK,
  output logic                    REN,
  output logic [ADDR_WIDTH-1:0]   RADDR,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    RVALID
);

  // One extra bit keeps BASE_ADDR+ADDR_SPAN from wrapping at the top.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] w_a;
    logic [ADDR_WIDTH:0] w_lo;
    logic [ADDR_WIDTH:0] w_hi;
    w_a  = {1'b0, a};
    w_lo = {1'b0, BASE_ADDR};
    w_hi = w_lo + ADDR_SPAN;
    return (w_a >= w_lo) && (w_a < w_hi);
  endfunction

  function automatic logic f_grant_wr(
    input logic wr,
    input logic rd,
    input logic last_wr
  );
    if (!rd) return wr;
    if (!wr) return 1'b0;
    if (ARB_MODE == 1) return 1'b1;
    return !last_wr;
  endfunction

  state_e r_state;
  state_e w_state_nxt;

  logic                    r_aw_held;
  logic                    r_w_held;
  logic                    r_wen;
  logic                    r_ren;
  logic                    r_last_wr;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [ADDR_WIDTH-1:0]   r_raddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]              r_bresp;
  logic [1:0]              r_rresp;

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_wen_set;
  logic                  w_ren_set;
  logic                  w_tmr_start;
  logic                  w_tmr_stop;
  logic                  w_expired;
  logic                  w_grant_wr;
  logic                  w_ar_in;
  logic                  w_aw_in;
  logic                  w_both;
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic                  w_unused;

  assign w_unused = ^{AXI_AWPROT, AXI_ARPROT};

  assign w_aw_hs    = AXI_AWVALID & w_awready;
  assign w_w_hs     = AXI_WVALID & w_wready;
  assign w_ar_hs    = AXI_ARVALID & w_arready;
  assign w_grant_wr = f_grant_wr(AXI_AWVALID | AXI_WVALID,
                                 AXI_ARVALID, r_last_wr);
  assign w_ar_in    = f_in_range(AXI_ARADDR);
  assign w_aw_addr  = r_aw_held ? r_waddr : AXI_AWADDR;
  assign w_aw_in    = f_in_range(w_aw_addr);
  // READY is !held in collect, so valid-or-held means accepted by now.
  assign w_both     = (r_aw_held | AXI_AWVALID) & (r_w_held | AXI_WVALID);

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_arready   = 1'b0;
    w_wen_set   = 1'b0;
    w_ren_set   = 1'b0;
    w_tmr_start = 1'b0;
    w_tmr_stop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_state_nxt = S_WR_COLLECT;
        end else if (AXI_ARVALID) begin
          w_arready = 1'b1;
          if (w_ar_in) begin
            w_state_nxt = S_RD_WAIT;
            w_ren_set   = 1'b1;
            w_tmr_start = 1'b1;
          end else begin
            w_state_nxt = S_RD_RESP;
          end
        end
      end
      S_WR_COLLECT: begin
        w_awready = !r_aw_held;
        w_wready  = !r_w_held;
        if (w_both) begin
          if (w_aw_in) begin
            w_state_nxt = S_WR_WAIT;
            w_wen_set   = 1'b1;
            w_tmr_start = 1'b1;
          end else begin
            w_state_nxt = S_WR_RESP;
          end
        end
      end
      S_WR_WAIT: begin
        if (WACK || w_expired) begin
          w_state_nxt = S_WR_RESP;
          w_tmr_stop  = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (RVALID || w_expired) begin
          w_state_nxt = S_RD_RESP;
          w_tmr_stop  = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (AXI_BREADY) w_state_nxt = S_IDLE;
      end
      S_RD_RESP: begin
        if (AXI_RREADY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_wen     <= 1'b0;
      r_ren     <= 1'b0;
      r_last_wr <= 1'b0;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_wen <= w_wen_set;
      r_ren <= w_ren_set;
      if (w_aw_hs) begin
        r_waddr   <= AXI_AWADDR;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= AXI_WDATA;
        r_wstrb  <= AXI_WSTRB;
        r_w_held <= 1'b1;
      end
      if (r_state == S_WR_COLLECT && w_both) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        if (!w_aw_in) r_bresp <= RESP_DECERR;
      end
      if (w_ar_hs) begin
        r_raddr <= AXI_ARADDR;
        if (!w_ar_in) begin
          r_rresp <= RESP_DECERR;
          r_rdata <= '0;
        end
      end
      // Acknowledge wins over a timeout landing in the same cycle.
      if (r_state == S_WR_WAIT) begin
        if (WACK)           r_bresp <= RESP_OKAY;
        else if (w_expired) r_bresp <= RESP_SLVERR;
      end
      if (r_state == S_RD_WAIT) begin
        if (RVALID) begin
          r_rresp <= RESP_OKAY;
          r_rdata <= RDATA;
        end else if (w_expired) begin
          r_rresp <= RESP_SLVERR;
          r_rdata <= '0;
        end
      end
      if (r_state == S_WR_RESP && AXI_BREADY) r_last_wr <= 1'b1;
      if (r_state == S_RD_RESP && AXI_RREADY) r_last_wr <= 1'b0;
    end
  end

  axil_native_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (AXI_ACLK),
    .i_rst     (AXI_ARESET),
    .i_start   (w_tmr_start),
    .i_stop    (w_tmr_stop),
    .o_expired (w_expired)
  );

  assign AXI_AWREADY = w_awready;
  assign AXI_WREADY  = w_wready;
  assign AXI_ARREADY = w_arready;
  assign AXI_BVALID  = (r_state == S_WR_RESP);
  assign AXI_RVALID  = (r_state == S_RD_RESP);
  assign AXI_BRESP   = r_bresp;
  assign AXI_RRESP   = r_rresp;
  assign AXI_RDATA   = r_rdata;
  assign WEN         = r_wen;
  assign WADDR       = r_waddr;
  assign WDATA       = r_wdata;
  assign WSTRB       = r_wstrb;
  assign REN         = r_ren;
  assign RADDR       = r_raddr;

endmodule
